raw_atom_arbiter: RTL and testbench

RAW_ATOM_ARBITER -- requirements
Module: raw_atom_arbiter

---
 rtl/raw_atom_pkg.sv | 30 +++
 rtl/raw_rr_arbiter.sv | 34 +++
 rtl/raw_atom_arbiter.sv | 158 +++++++++++++++
 tb/tb_raw_atom_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raw_atom_pkg.sv
// Shared types and the operand arithmetic for the raw_atom_arbiter block.
// Optional statistics outputs are enabled by RAW_ATOM_ARBITER_STATS_EN.
package raw_atom_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int COUNT_WIDTH_DEF = 32;

  // Operand datapath width; COUNT_WIDTH must stay below this.
  localparam int OP_W = 64;

  // new = (sel1 ? pkt : constant) + (sel2 ? 0 : state); the caller keeps the low bits.
  function automatic logic [OP_W-1:0] atom_op(
    input logic [OP_W-1:0] pkt,
    input logic [OP_W-1:0] cst,
    input logic [OP_W-1:0] cur,
    input logic            sel1,
    input logic            sel2
  );
    logic [OP_W-1:0] lhs;
    logic [OP_W-1:0] rhs;
    lhs = sel1 ? pkt : cst;
    rhs = sel2 ? '0 : cur;
    return lhs + rhs;
  endfunction

endpackage

// File: rtl/raw_rr_arbiter.sv
// Round-robin grant: first valid requester at or above the pointer, wrapping.
// Purely combinational; the owner advances the pointer on accept.
module raw_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    int               pos;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = IDX_W'(pos);
      if (!grant_any && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/raw_atom_arbiter.sv
// Round-robin arbiter serialising read-modify-write ops on one shared state register.
// Define RAW_ATOM_ARBITER_STATS_EN to add the op/stall counter outputs.
module raw_atom_arbiter
  import raw_atom_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int NUM_REQ     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [COUNT_WIDTH-1:0]         i__constant,
  input  logic [NUM_REQ-1:0]             i__req_valid,
  output logic [NUM_REQ-1:0]             o__req_ready,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] i__req_pkt,
  input  logic [NUM_REQ-1:0]             i__req_sel1,
  input  logic [NUM_REQ-1:0]             i__req_sel2,
  input  logic                           i__clear,
  output logic                           o__rsp_valid,
  input  logic                           i__rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]     o__rsp_id,
  output logic [COUNT_WIDTH-1:0]         o__rsp_read,
  output logic [COUNT_WIDTH-1:0]         o__rsp_write
`ifdef RAW_ATOM_ARBITER_STATS_EN
  ,
  output logic [31:0]                    o__op_count,
  output logic [31:0]                    o__stall_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e                      fsm_q, fsm_d;
  logic [COUNT_WIDTH-1:0]      state_q;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic [NUM_REQ-1:0]          grant;
  logic [IDX_W-1:0]            grant_idx;
  logic                        grant_any;
  logic                        accept;

  logic [COUNT_WIDTH-1:0]      pkt_sel;
  logic                        sel1, sel2;
  logic [OP_W-1:0]             pkt_ext, cst_ext, cur_ext, op_res;
  logic [OP_W-COUNT_WIDTH-1:0] op_hi_unused;
  logic [COUNT_WIDTH-1:0]      new_val;

  logic                        rsp_vld_p1;
  logic [IDX_W-1:0]            rsp_id_p1;
  logic [COUNT_WIDTH-1:0]      rsp_read_p1, rsp_write_p1;

  raw_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .valid     (i__req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Accept only in RUN when the response slot is free or draining this cycle;
  // HOLD blocks every requester regardless of rsp_ready.
  always_comb begin
    fsm_d        = fsm_q;
    accept       = 1'b0;
    o__req_ready = '0;
    unique case (fsm_q)
      ST_RUN: begin
        if (!rst && !i__clear && grant_any && (!rsp_vld_p1 || i__rsp_ready))
          accept = 1'b1;
        if (rsp_vld_p1 && !i__rsp_ready)
          fsm_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (i__rsp_ready)
          fsm_d = ST_RUN;
      end
      default: fsm_d = ST_RUN;
    endcase
    if (accept)
      o__req_ready = grant;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept)
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    pkt_sel = '0;
    sel1    = 1'b0;
    sel2    = 1'b0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (grant[n]) begin
        pkt_sel = i__req_pkt[n*COUNT_WIDTH +: COUNT_WIDTH];
        sel1    = i__req_sel1[n];
        sel2    = i__req_sel2[n];
      end
    end
    pkt_ext                    = '0;
    cst_ext                    = '0;
    cur_ext                    = '0;
    pkt_ext[COUNT_WIDTH-1:0]   = pkt_sel;
    cst_ext[COUNT_WIDTH-1:0]   = i__constant;
    cur_ext[COUNT_WIDTH-1:0]   = state_q;
    op_res                     = atom_op(pkt_ext, cst_ext, cur_ext, sel1, sel2);
    {op_hi_unused, new_val}    = op_res;
  end

  // Stage p0 -> p1: state written on the accept edge, response registered alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= ST_RUN;
      ptr_q        <= '0;
      state_q      <= '0;
      rsp_vld_p1   <= 1'b0;
      rsp_id_p1    <= '0;
      rsp_read_p1  <= '0;
      rsp_write_p1 <= '0;
    end else begin
      fsm_q <= fsm_d;
      ptr_q <= ptr_d;
      if (i__clear)
        state_q <= '0;
      else if (accept)
        state_q <= new_val;
      if (accept) begin
        rsp_vld_p1   <= 1'b1;
        rsp_id_p1    <= grant_idx;
        rsp_read_p1  <= state_q;
        rsp_write_p1 <= new_val;
      end else if (rsp_vld_p1 && i__rsp_ready) begin
        rsp_vld_p1 <= 1'b0;
      end
    end
  end

  assign o__rsp_valid = rsp_vld_p1;
  assign o__rsp_id    = rsp_id_p1;
  assign o__rsp_read  = rsp_read_p1;
  assign o__rsp_write = rsp_write_p1;

`ifdef RAW_ATOM_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o__op_count    <= '0;
      o__stall_count <= '0;
    end else begin
      if (accept)
        o__op_count <= o__op_count + 32'd1;
      if (fsm_q == ST_HOLD && |i__req_valid)
        o__stall_count <= o__stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_raw_atom_arbiter.sv
// Self-checking bench for raw_atom_arbiter: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_raw_atom_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   cst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] pkt;
  logic [N-1:0]   sel1, sel2;
  logic           clear;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_read, rsp_write;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model
  logic [W-1:0] m_state;
  int           m_ptr;
  bit           m_stalled;
  bit           m_rv;
  int           m_id;
  logic [W-1:0] m_rd, m_wr;

  always #5 clk = ~clk;

  raw_atom_arbiter #(.COUNT_WIDTH(W), .NUM_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .i__constant  (cst),
    .i__req_valid (req_valid),
    .o__req_ready (req_ready),
    .i__req_pkt   (pkt),
    .i__req_sel1  (sel1),
    .i__req_sel2  (sel2),
    .i__clear     (clear),
    .o__rsp_valid (rsp_valid),
    .i__rsp_ready (rsp_ready),
    .o__rsp_id    (rsp_id),
    .o__rsp_read  (rsp_read),
    .o__rsp_write (rsp_write)
  );

  task automatic model_reset();
    m_state   = '0;
    m_ptr     = 0;
    m_stalled = 1'b0;
    m_rv      = 1'b0;
    m_id      = 0;
    m_rd      = '0;
    m_wr      = '0;
  endtask

  // Requester accepted this cycle under current inputs, or -1.
  function automatic int m_grant();
    if (rst || clear || m_stalled) return -1;
    if (m_rv && !rsp_ready) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready_vec();
    int k;
    k = m_grant();
    return (k >= 0) ? N'(1 << k) : '0;
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    int           k;
    logic [W-1:0] a, b, nv;
    bit           now_stalled;
    k  = m_grant();
    nv = '0;
    if (k >= 0) begin
      a  = sel1[k] ? pkt[k*W +: W] : cst;
      b  = sel2[k] ? '0 : m_state;
      nv = a + b;
    end
    now_stalled = m_rv && !rsp_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (k >= 0) begin
        m_rd    = m_state;
        m_wr    = nv;
        m_id    = k;
        m_rv    = 1'b1;
        m_state = nv;
        m_ptr   = (k + 1) % N;
      end else if (m_rv && rsp_ready) begin
        m_rv = 1'b0;
      end
      if (clear) m_state = '0;
      m_stalled = now_stalled;
    end
    #1;
  endtask

  task automatic set_req(input int n, input bit v, input logic [W-1:0] p,
                         input bit s1, input bit s2);
    req_valid[n]    = v;
    pkt[n*W +: W]   = p;
    sel1[n]         = s1;
    sel2[n]         = s2;
  endtask

  task automatic idle();
    req_valid = '0;
    sel1      = '0;
    sel2      = '0;
    clear     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); pkt = '0; cst = '0; rsp_ready = 1'b1;
    req_valid = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_tests++;
    if (rsp_id !== 2'd0 || rsp_read !== '0 || rsp_write !== '0) begin
      n_fail++; $display("FAIL reset_rsp_fields got id=%0d rd=%h wr=%h want 0/0/0", rsp_id, rsp_read, rsp_write);
    end
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd5, 1'b1, 1'b0);
    #2;
    n_tests++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL basic_ready1 got %b want 0001", req_ready); end
    tick(); #2;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_read !== 32'd0 || rsp_write !== 32'd5) begin
      n_fail++; $display("FAIL basic_op1 got v=%b id=%0d rd=%0d wr=%0d want 1/0/0/5", rsp_valid, rsp_id, rsp_read, rsp_write);
    end
    n_tests++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL basic_ready2 got %b want 0001", req_ready); end
    tick(); #2;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_read !== 32'd5 || rsp_write !== 32'd10) begin
      n_fail++; $display("FAIL basic_op2 got v=%b rd=%0d wr=%0d want 1/5/10", rsp_valid, rsp_read, rsp_write);
    end
    idle();
    tick(); #2;
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int exp_id[5] = '{0, 1, 2, 3, 0};
    rsp_ready = 1'b1;
    idle();
    set_req(3, 1'b1, 32'd1, 1'b1, 1'b0);
    tick();
    for (int n = 0; n < N; n++) set_req(n, 1'b1, 32'(n + 1), 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #2;
      n_tests++;
      if (req_ready !== N'(1 << exp_id[c])) begin
        n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", c, req_ready, N'(1 << exp_id[c]));
      end
      tick(); #2;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id[c])) begin
        n_fail++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d want 1/%0d", c, rsp_valid, rsp_id, exp_id[c]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    idle(); clear = 1'b1;
    tick();
    clear = 1'b0;
    cst = 32'hFFFF_FFFF;
    set_req(0, 1'b1, 32'd0, 1'b0, 1'b1);
    tick(); #2;
    n_tests++;
    if (rsp_write !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_setup got %h want ffffffff", rsp_write); end
    set_req(0, 1'b1, 32'd2, 1'b1, 1'b0);
    tick(); #2;
    n_tests++;
    if (rsp_read !== 32'hFFFF_FFFF || rsp_write !== 32'h0000_0001) begin
      n_fail++; $display("FAIL wrap_result got rd=%h wr=%h want ffffffff/00000001", rsp_read, rsp_write);
    end
    idle();
    tick();
  endtask

  task automatic test_hold();
    rsp_ready = 1'b1;
    idle();
    set_req(1, 1'b1, 32'd3, 1'b1, 1'b1);
    tick();
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_tests++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL hold_ready[%0d] got %b want 0000", c, req_ready); end
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_write !== 32'd3) begin
        n_fail++; $display("FAIL hold_stable[%0d] got v=%b id=%0d wr=%0d want 1/1/3", c, rsp_valid, rsp_id, rsp_write);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #2;
    n_tests++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL hold_release got rdy=%b v=%b want 0000/1", req_ready, rsp_valid);
    end
    tick(); #2;
    n_tests++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_resume got %b want 0010", req_ready); end
    tick(); #2;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL hold_resume_rsp got v=%b id=%0d want 1/1", rsp_valid, rsp_id);
    end
    idle();
    tick();
  endtask

  task automatic test_clear();
    rsp_ready = 1'b1;
    idle();
    set_req(2, 1'b1, 32'd99, 1'b1, 1'b0);
    clear = 1'b1;
    #2;
    n_tests++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL clear_ready got %b want 0000", req_ready); end
    tick();
    clear = 1'b0;
    cst = 32'd7;
    set_req(2, 1'b1, 32'd99, 1'b0, 1'b0);
    #2;
    n_tests++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL clear_next_ready got %b want 0100", req_ready); end
    tick(); #2;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_read !== 32'd0 || rsp_write !== 32'd7) begin
      n_fail++; $display("FAIL clear_op got v=%b id=%0d rd=%0d wr=%0d want 1/2/0/7", rsp_valid, rsp_id, rsp_read, rsp_write);
    end
    idle();
    tick();
  endtask

  task automatic test_rst_in_hold();
    rsp_ready = 1'b1;
    idle();
    set_req(0, 1'b1, 32'd9, 1'b1, 1'b1);
    tick();
    idle();
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_read !== '0 || rsp_write !== '0) begin
      n_fail++; $display("FAIL rst_hold_rsp got v=%b rd=%h wr=%h want 0/0/0", rsp_valid, rsp_read, rsp_write);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    cst = 32'd11;
    for (int n = 0; n < N; n++) set_req(n, 1'b1, 32'd0, 1'b0, 1'b0);
    #2;
    n_tests++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_hold_ptr got %b want 0001", req_ready); end
    tick(); #2;
    n_tests++;
    if (rsp_id !== 2'd0 || rsp_read !== 32'd0 || rsp_write !== 32'd11) begin
      n_fail++; $display("FAIL rst_hold_state got id=%0d rd=%0d wr=%0d want 0/0/11", rsp_id, rsp_read, rsp_write);
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_rdy;
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      sel1      = N'($urandom);
      sel2      = N'($urandom);
      for (int n = 0; n < N; n++) pkt[n*W +: W] = $urandom;
      cst       = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 15) == 0);
      #2;
      exp_rdy = m_ready_vec();
      n_tests++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", c, req_ready, exp_rdy);
      end
      n_tests++;
      if (rsp_valid !== m_rv) begin
        n_fail++; $display("FAIL rand_rsp_valid[%0d] got %b want %b", c, rsp_valid, m_rv);
      end
      if (m_rv) begin
        n_tests++;
        if (rsp_id !== 2'(m_id) || rsp_read !== m_rd || rsp_write !== m_wr) begin
          n_fail++; $display("FAIL rand_rsp[%0d] got id=%0d rd=%h wr=%h want %0d/%h/%h",
                             c, rsp_id, rsp_read, rsp_write, m_id, m_rd, m_wr);
        end
      end
      tick();
    end
    idle();
    rsp_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_hold();
    test_clear();
    test_rst_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
